// File: rtl/timer_pkg.sv
// Shared definitions for the timer reload sequencer: default widths and the
// reload FSM state encoding.
package timer_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD_LO = 2'b01,
    LOAD_HI = 2'b10
  } reload_state_e;

endpackage

// File: rtl/timer_match_det.sv
// Compare-match detector: flags only the cycle where cnt first equals cmp_val,
// so a counter parked on the compare value yields a single event.
module timer_match_det
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic             timer_en,
  output logic             match_evt
);

  logic match;
  logic match_q;

  assign match = (cnt == cmp_val);

  // match_q tracks the raw compare even while disabled, so re-enabling on a
  // parked counter does not fire.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

  assign match_evt = match & ~match_q & timer_en;

endmodule

// File: rtl/timer_reload_ctrl.sv
// Compare-match status and two-beat auto-reload sequencer for the 64-bit
// timer; shares the counter write port with software, which always wins.
module timer_reload_ctrl
  import timer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              timer_en,
  input  logic [CNT_W-1:0]  cmp_val,
  input  logic [CNT_W-1:0]  reload_val,
  input  logic              periodic,
  input  logic              int_en,
  input  logic              int_clr,
  input  logic              sw_tdr0_wr_sel,
  input  logic              sw_tdr1_wr_sel,
  input  logic [DATA_W-1:0] sw_wdata_cnt,
  output logic              tdr0_wr_sel,
  output logic              tdr1_wr_sel,
  output logic [DATA_W-1:0] wdata_cnt,
  output logic              cnt_hold,
  output logic              oneshot_stop,
  output logic              int_st,
  output logic              reload_ovr,
  output logic              tim_int,
  output logic [1:0]        dbg_state
);

  // Handshake: the counter write port has no back-pressure; a strobe high in
  // a cycle means the counter captures wdata_cnt on that cycle's rising edge.

  reload_state_e state_q;
  logic          int_st_q;
  logic          reload_ovr_q;
  logic          oneshot_q;
  logic          match_evt;
  logic          sw_wr;

  timer_match_det #(
    .CNT_W(CNT_W)
  ) u_match_det (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .cnt      (cnt),
    .cmp_val  (cmp_val),
    .timer_en (timer_en),
    .match_evt(match_evt)
  );

  assign sw_wr = sw_tdr0_wr_sel | sw_tdr1_wr_sel;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      int_st_q     <= 1'b0;
      reload_ovr_q <= 1'b0;
      oneshot_q    <= 1'b0;
    end else begin
      oneshot_q <= match_evt & ~periodic;
      // A new match outranks a simultaneous clear so no event is lost.
      if (match_evt) begin
        int_st_q <= 1'b1;
      end else if (int_clr) begin
        int_st_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (match_evt && periodic) begin
            state_q <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (sw_wr) begin
            state_q      <= IDLE;
            reload_ovr_q <= 1'b1;
          end else begin
            state_q <= LOAD_HI;
          end
        end
        LOAD_HI: begin
          state_q <= IDLE;
          if (sw_wr) begin
            reload_ovr_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    tdr0_wr_sel = 1'b0;
    tdr1_wr_sel = 1'b0;
    wdata_cnt   = '0;
    if (sw_wr) begin
      tdr0_wr_sel = sw_tdr0_wr_sel;
      tdr1_wr_sel = sw_tdr1_wr_sel;
      wdata_cnt   = sw_wdata_cnt;
    end else if (state_q == LOAD_LO) begin
      tdr0_wr_sel = 1'b1;
      wdata_cnt   = reload_val[DATA_W-1:0];
    end else if (state_q == LOAD_HI) begin
      tdr1_wr_sel = 1'b1;
      wdata_cnt   = reload_val[CNT_W-1:DATA_W];
    end
  end

  assign cnt_hold     = (state_q != IDLE) & ~sw_wr;
  assign oneshot_stop = oneshot_q;
  assign int_st       = int_st_q;
  assign reload_ovr   = reload_ovr_q;
  assign tim_int      = int_st_q & int_en;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_timer_reload_ctrl.sv
// Bench for timer_reload_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a timeline model of pending reload write cycles.
module tb_timer_reload_ctrl;
  import timer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [63:0] cnt;
  logic        timer_en;
  logic [63:0] cmp_val;
  logic [63:0] reload_val;
  logic        periodic;
  logic        int_en;
  logic        int_clr;
  logic        sw0;
  logic        sw1;
  logic [31:0] sw_wdata;
  logic        tdr0_wr_sel;
  logic        tdr1_wr_sel;
  logic [31:0] wdata_cnt;
  logic        cnt_hold;
  logic        oneshot_stop;
  logic        int_st;
  logic        reload_ovr;
  logic        tim_int;
  logic [1:0]  dbg_state;

  timer_reload_ctrl #(.DATA_W(32), .CNT_W(64)) dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .cnt           (cnt),
    .timer_en      (timer_en),
    .cmp_val       (cmp_val),
    .reload_val    (reload_val),
    .periodic      (periodic),
    .int_en        (int_en),
    .int_clr       (int_clr),
    .sw_tdr0_wr_sel(sw0),
    .sw_tdr1_wr_sel(sw1),
    .sw_wdata_cnt  (sw_wdata),
    .tdr0_wr_sel   (tdr0_wr_sel),
    .tdr1_wr_sel   (tdr1_wr_sel),
    .wdata_cnt     (wdata_cnt),
    .cnt_hold      (cnt_hold),
    .oneshot_stop  (oneshot_stop),
    .int_st        (int_st),
    .reload_ovr    (reload_ovr),
    .tim_int       (tim_int),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bench-side counter and reference model
  logic [63:0] cnt_m;
  logic        count_en;
  logic        m_int_st, m_ovr, m_oneshot, m_prev_eq;
  int          m_lo, m_hi, cyc;
  int          n_cmp, n_err;
  int          n_t0, n_t1, n_os;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_int_st  = 1'b0;
    m_ovr     = 1'b0;
    m_oneshot = 1'b0;
    m_prev_eq = 1'b0;
    m_lo      = -1;
    m_hi      = -1;
  endtask

  task automatic set_defaults();
    timer_en = 1'b1; periodic = 1'b1; int_en = 1'b1; int_clr = 1'b0;
    sw0 = 1'b0; sw1 = 1'b0; sw_wdata = '0; count_en = 1'b1; rst_n = 1'b1;
  endtask

  task automatic clr_counts();
    n_t0 = 0; n_t1 = 0; n_os = 0;
  endtask

  // One clock cycle: drive cnt, check outputs before the edge, advance model.
  task automatic step();
    logic        eq, evt, busy, sw;
    logic        e_t0, e_t1, e_hold;
    logic [31:0] e_wd;
    logic [1:0]  e_st;
    cnt = cnt_m;
    #1;
    eq   = (cnt == cmp_val);
    evt  = eq && !m_prev_eq && timer_en;
    busy = (cyc == m_lo) || (cyc == m_hi);
    sw   = sw0 | sw1;
    e_t0 = 1'b0; e_t1 = 1'b0; e_wd = '0;
    if (sw) begin
      e_t0 = sw0; e_t1 = sw1; e_wd = sw_wdata;
    end else if (cyc == m_lo) begin
      e_t0 = 1'b1; e_wd = reload_val[31:0];
    end else if (cyc == m_hi) begin
      e_t1 = 1'b1; e_wd = reload_val[63:32];
    end
    e_hold = busy && !sw;
    e_st = (cyc == m_lo) ? LOAD_LO : (cyc == m_hi) ? LOAD_HI : IDLE;
    check("tdr0_wr_sel", tdr0_wr_sel, e_t0);
    check("tdr1_wr_sel", tdr1_wr_sel, e_t1);
    check("wdata_cnt", wdata_cnt, e_wd);
    check("cnt_hold", cnt_hold, e_hold);
    check("oneshot_stop", oneshot_stop, m_oneshot);
    check("int_st", int_st, m_int_st);
    check("reload_ovr", reload_ovr, m_ovr);
    check("tim_int", tim_int, m_int_st & int_en);
    check("state", dbg_state, e_st);
    if (tdr0_wr_sel) n_t0++;
    if (tdr1_wr_sel) n_t1++;
    if (oneshot_stop) n_os++;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_prev_eq = eq;
      if (evt) m_int_st = 1'b1;
      else if (int_clr) m_int_st = 1'b0;
      m_oneshot = evt && !periodic;
      if (sw && busy) begin
        m_ovr = 1'b1; m_lo = -1; m_hi = -1;
      end
      if (evt && periodic && !busy) begin
        m_lo = cyc + 1; m_hi = cyc + 2;
      end
    end
    if (e_t0 || e_t1) begin
      if (e_t0) cnt_m[31:0] = e_wd;
      if (e_t1) cnt_m[63:32] = e_wd;
    end else if (count_en && !e_hold) begin
      cnt_m = cnt_m + 64'd1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    set_defaults();
    rst_n = 1'b0;
    cmp_val = 64'hFFFF; reload_val = '0; cnt_m = '0; cnt = '0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // periodic reload across the word boundary
    cmp_val = 64'h0000_0001_0000_0010; reload_val = 64'h5;
    cnt_m = 64'h0000_0001_0000_000E; clr_counts();
    steps(8);
    check("periodic_lo_writes", n_t0, 1);
    check("periodic_hi_writes", n_t1, 1);

    // one-shot with int_en toggled
    periodic = 1'b0; cmp_val = 64'h20; cnt_m = 64'h1E; clr_counts();
    steps(4);
    int_en = 1'b0;
    steps(2);
    int_en = 1'b1;
    check("oneshot_pulses", n_os, 1);
    check("oneshot_no_strobes", n_t0 + n_t1, 0);

    // clear collides with match edge: set wins, later clear takes effect
    cnt_m = 64'h1F; int_clr = 1'b1;
    step();
    step();
    check("prio_set_wins", int_st, 1);
    step();
    int_clr = 1'b0;
    check("prio_clear_later", int_st, 0);
    steps(2);

    // software write pre-empts the low beat
    periodic = 1'b1; cmp_val = 64'h40; reload_val = 64'h77; cnt_m = 64'h3F; clr_counts();
    steps(2);
    sw1 = 1'b1; sw_wdata = 32'hDEAD_BEEF;
    step();
    sw1 = 1'b0; sw_wdata = '0;
    steps(3);
    check("preempt_ovr", reload_ovr, 1);
    check("preempt_no_lo", n_t0, 0);
    check("preempt_only_sw_hi", n_t1, 1);

    // stuck match on a parked counter
    count_en = 1'b0; cmp_val = 64'h100; reload_val = 64'h100; cnt_m = 64'h100; clr_counts();
    steps(10);
    check("stuck_lo_writes", n_t0, 1);
    check("stuck_hi_writes", n_t1, 1);
    count_en = 1'b1;

    // timer_en low suppresses the event
    timer_en = 1'b0; cmp_val = 64'h300; cnt_m = 64'h2FE; clr_counts();
    steps(5);
    check("disabled_no_reload", n_t0, 0);
    timer_en = 1'b1;

    // reset during LOAD_HI, then a normal reload afterwards
    cmp_val = 64'h200; reload_val = 64'h1F0; cnt_m = 64'h1FF;
    steps(3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_int_st", int_st, 0);
    check("rst_ovr", reload_ovr, 0);
    clr_counts();
    steps(24);
    check("post_rst_lo_writes", n_t0, 1);
    check("post_rst_hi_writes", n_t1, 1);

    // wrap: all-ones compare, then compare at zero across the wrap
    cmp_val = '1; reload_val = 64'h10; cnt_m = 64'hFFFF_FFFF_FFFF_FFFD;
    steps(6);
    periodic = 1'b0; cmp_val = '0; cnt_m = 64'hFFFF_FFFF_FFFF_FFFE; clr_counts();
    steps(4);
    check("wrap_zero_oneshot", n_os, 1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) begin
        periodic = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0: cmp_val = '1;
          1: cmp_val = '0;
          default: cmp_val = {$urandom, $urandom};
        endcase
        reload_val = ($urandom_range(0, 5) == 0) ? cmp_val : {$urandom, $urandom};
      end
      if (i % 13 == 0) cnt_m = cmp_val - 64'($urandom_range(0, 4));
      timer_en = ($urandom_range(0, 7) != 0);
      int_en   = 1'($urandom_range(0, 1));
      int_clr  = ($urandom_range(0, 5) == 0);
      count_en = ($urandom_range(0, 5) != 0);
      sw0      = ($urandom_range(0, 19) == 0);
      sw1      = ($urandom_range(0, 19) == 0);
      sw_wdata = $urandom;
      rst_n    = ($urandom_range(0, 99) != 0);
      step();
    end
    set_defaults();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/timer_reload_ctrl.md
Name: timer_reload_ctrl

Overview:
- Compare-match and auto-reload sequencer for the 64-bit timer counter.
- Detects cnt == compare value, raises the sticky interrupt status and the tim_int line, and in periodic mode reloads the counter over its 32-bit write port in two beats (low, then high).
- Arbitrates the counter write port between software register writes and hardware reload; software always has priority.
- Sits between the register block, control_counter and counter_64bit.

Parameters:
- DATA_W, 32, counter write-port width.
- CNT_W, 64, counter width; must equal 2*DATA_W.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  synchronous active-low reset, sampled on the sys_clk rising edge.
- cnt  in  CNT_W  current counter value.
- timer_en  in  1  timer enable from the register block.
- cmp_val  in  CNT_W  compare value.
- reload_val  in  CNT_W  reload value.
- periodic  in  1  1 = periodic (auto-reload), 0 = one-shot.
- int_en  in  1  interrupt enable.
- int_clr  in  1  W1C pulse that clears int_st.
- sw_tdr0_wr_sel  in  1  software write, counter low word.
- sw_tdr1_wr_sel  in  1  software write, counter high word.
- sw_wdata_cnt  in  DATA_W  software write data.
- tdr0_wr_sel  out  1  to counter, low-word write strobe.
- tdr1_wr_sel  out  1  to counter, high-word write strobe.
- wdata_cnt  out  DATA_W  to counter, write data.
- cnt_hold  out  1  gates count_en while a reload is in progress.
- oneshot_stop  out  1  one-cycle request to clear timer_en.
- int_st  out  1  sticky match status.
- reload_ovr  out  1  sticky flag: a reload was aborted by a software write.
- tim_int  out  1  interrupt line.

Behaviour:
- Reset (sys_rst_n = 0 at a clock edge):
  - State = IDLE; int_st, reload_ovr, match_q and oneshot_stop = 0.
  - All outputs 0; tim_int = 0.
  - Reset asserted mid-reload abandons the reload; no further write strobes are issued.
- Match detection:
  - match = (cnt == cmp_val); match_q is match registered.
  - match_evt = match & ~match_q & timer_en (rising edge only).
  - A counter that stays equal to cmp_val produces exactly one event.
- Status:
  - int_st is set in the cycle after match_evt.
  - int_clr clears int_st.
  - If match_evt and int_clr occur in the same cycle, set wins.
  - tim_int = int_st & int_en (combinational).
- FSM states: IDLE, LOAD_LO, LOAD_HI.
  - IDLE -> LOAD_LO on match_evt & periodic.
  - LOAD_LO -> LOAD_HI unconditionally.
  - LOAD_HI -> IDLE unconditionally.
  - Any state -> IDLE if (sw_tdr0_wr_sel | sw_tdr1_wr_sel) in LOAD_LO/LOAD_HI; reload_ovr is set.
  - reload_ovr clears only on reset.
- Output mux (combinational from state and software inputs):
  - A software strobe active: pass the software strobes and sw_wdata_cnt straight through.
  - LOAD_LO: tdr0_wr_sel = 1, wdata_cnt = reload_val[DATA_W-1:0].
  - LOAD_HI: tdr1_wr_sel = 1, wdata_cnt = reload_val[CNT_W-1:DATA_W].
  - Otherwise: strobes = 0, wdata_cnt = 0.
- cnt_hold = 1 in LOAD_LO and LOAD_HI, except in a cycle where a software write aborts the reload.
- Latency, match seen at cycle N:
  - int_st and tim_int rise at N+1.
  - Low-word write at N+1, high-word write at N+2.
  - Counter holds reload_val from N+3 and resumes counting at N+3.
- One-shot mode: match_evt & ~periodic pulses oneshot_stop for one cycle at N+1; no reload.
- timer_en = 0 suppresses new events. A reload already in progress completes.
- Wrap-around: cmp_val = 2^64-1 matches normally. Counter wrap from all-ones to 0 is not a match unless cmp_val = 0.
- reload_val == cmp_val: the edge detector prevents immediate re-trigger; the next event needs cnt to leave and return to cmp_val.

Decomposition:
- Shared package timer_pkg:
  - FSM state encoding constants (IDLE = 2'b00, LOAD_LO = 2'b01, LOAD_HI = 2'b10).
  - DATA_W and CNT_W defaults.
- One sub-module, timer_match_det: comparator plus match_q edge register, output match_evt.
- The FSM, status flags and output mux stay in timer_reload_ctrl.

Test Plan:
- Periodic reload: cmp_val = 0x0000_0001_0000_0010, reload_val = 0x5, periodic = 1, timer_en = 1, count from 0x0000_0001_0000_000E.
  - Required: int_st = 1 one cycle after the match.
  - Required: tdr0 write of 0x5, then tdr1 write of 0x0 on consecutive cycles, with cnt_hold = 1 for both.
  - Required: cnt = 0x5 afterwards.
- One-shot: periodic = 0, cmp_val = 0x20.
  - Required: oneshot_stop pulses once, no tdr strobes, tim_int = 1 with int_en = 1 and 0 with int_en = 0.
- Status priority: int_clr in the same cycle as the match edge -> int_st stays 1. int_clr one cycle later -> int_st = 0.
- Software pre-emption: sw_tdr1_wr_sel with data 0xDEAD_BEEF during LOAD_LO.
  - Required: tdr1_wr_sel = 1 with wdata_cnt = 0xDEAD_BEEF.
  - Required: FSM returns to IDLE, no LOAD_HI beat, reload_ovr = 1.
- Stuck match: hold cnt = cmp_val = 0x100 (count_en = 0) for 10 cycles -> exactly one event, one reload sequence.
- Reset in LOAD_HI: sys_rst_n = 0 for one cycle.
  - Required: all outputs 0 on the next cycle and state IDLE.
  - Required: the next match_evt still triggers a normal reload.
